// File: rtl/mult_ctrl.sv
// Sequencing FSM for the N-bit shift-and-add multiplier datapath (A, B, P registers).
// Latency: 2 edges to first CHECK, 2-3 edges per iteration, 1 edge to DONE; at most 3N+3 edges.
// Backpressure: start/done four-phase handshake; DONE holds until start drops, start ignored while busy.
module mult_ctrl #(
    parameter int N = 4,
    localparam int IW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          zero,
    input  logic          lsb_b,
    output logic          en_a,
    output logic          ld_shift_a,
    output logic          en_b,
    output logic          ld_shift_b,
    output logic          en_p,
    output logic          ld_add_p,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Guard value: once N shifts are done every multiplier bit has been consumed.
    localparam logic [IW-1:0] ITER_MAX = IW'(N);

    state_t state;
    state_t state_nxt;

    // State register; clr wins over every transition.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift counter: cleared by LOAD, bumped once per SHIFT, held elsewhere.
    always_ff @(posedge clk) begin
        if (clr) begin
            iter <= '0;
        end else if (state == S_LOAD) begin
            iter <= '0;
        end else if (state == S_SHIFT) begin
            iter <= iter + 1'b1;
        end
    end

    // Next-state decode from current state and datapath flags.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt = S_CHECK;
            S_CHECK: begin
                if (zero || (iter == ITER_MAX)) begin
                    state_nxt = S_DONE;
                end else if (lsb_b) begin
                    state_nxt = S_ADD;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = S_CHECK;
            S_DONE:  state_nxt = start ? S_DONE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode: controls depend on state only, never on inputs.
    always_comb begin
        en_a       = 1'b0;
        ld_shift_a = 1'b0;
        en_b       = 1'b0;
        ld_shift_b = 1'b0;
        en_p       = 1'b0;
        ld_add_p   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_LOAD: begin
                en_a       = 1'b1;
                ld_shift_a = 1'b1;
                en_b       = 1'b1;
                ld_shift_b = 1'b1;
                en_p       = 1'b1;
                ld_add_p   = 1'b1;
                busy       = 1'b1;
            end
            S_CHECK: begin
                busy = 1'b1;
            end
            S_ADD: begin
                en_p = 1'b1;
                busy = 1'b1;
            end
            S_SHIFT: begin
                en_a = 1'b1;
                en_b = 1'b1;
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
